// File: rtl/diff_stream_codec.sv
// Streaming differential encoder/decoder for base-2^B digit strands.
// Optional DIFF_STATS_EN adds beat/strand counters with a synchronous clear.
module diff_stream_codec #(
  parameter int N = 100,
  parameter int B = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [N*B-1:0] s_data,
  input  logic         s_first,
  input  logic         s_last,
  input  logic         s_mode,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N*B-1:0] m_data,
`ifdef DIFF_STATS_EN
  input  logic         stat_clr,
  output logic [31:0]  stat_beats,
  output logic [31:0]  stat_strands,
`endif
  output logic         m_last
);

  localparam int W = N * B;

  logic         m_valid_q;
  logic [W-1:0] m_data_q;
  logic         m_last_q;
  logic [B-1:0] carry_q;
  logic         open_q;

  logic [W-1:0] data_d;
  logic [B-1:0] carry_d;
  logic [B-1:0] prev;
  logic [B-1:0] acc;
  logic [B-1:0] din;
  logic [B-1:0] last_in;
  logic         accept;

  assign s_ready = !m_valid_q || m_ready;
  assign accept  = s_valid && s_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;

  // Walk digits in time order; acc is the decode ripple, last_in the raw
  // predecessor used for encode.
  always_comb begin
    prev    = (s_first || !open_q) ? '0 : carry_q;
    acc     = prev;
    last_in = prev;
    din     = '0;
    data_d  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      din = s_data[B*i +: B];
      if (s_mode) begin
        acc = acc + din;
        data_d[B*i +: B] = acc;
      end else begin
        data_d[B*i +: B] = din - last_in;
      end
      last_in = din;
    end
    carry_d = s_mode ? acc : s_data[B-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      carry_q   <= '0;
      open_q    <= 1'b0;
    end else begin
      if (accept) begin
        m_valid_q <= 1'b1;
        m_data_q  <= data_d;
        m_last_q  <= s_last;
        carry_q   <= s_last ? '0 : carry_d;
        open_q    <= !s_last;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

`ifdef DIFF_STATS_EN
  logic [31:0] beats_q;
  logic [31:0] strands_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_q   <= '0;
      strands_q <= '0;
    end else if (stat_clr) begin
      beats_q   <= '0;
      strands_q <= '0;
    end else if (accept) begin
      beats_q <= beats_q + 32'd1;
      if (s_last) strands_q <= strands_q + 32'd1;
    end
  end

  assign stat_beats   = beats_q;
  assign stat_strands = strands_q;
`endif

endmodule

// File: tb/tb_diff_stream_codec.sv
// Scoreboard bench for diff_stream_codec at N=4, B=2.
// Digit lists are written MSB (first in time) first.
module tb_diff_stream_codec;

  localparam int N = 4;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         s_first;
  logic         s_last;
  logic         s_mode;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_last;
`ifdef DIFF_STATS_EN
  logic         stat_clr = 1'b0;
  logic [31:0]  stat_beats;
  logic [31:0]  stat_strands;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] expq[$];

  always #5 clk = ~clk;

  diff_stream_codec #(.N(N), .B(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_first (s_first),
    .s_last  (s_last),
    .s_mode  (s_mode),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
`ifdef DIFF_STATS_EN
    .stat_clr     (stat_clr),
    .stat_beats   (stat_beats),
    .stat_strands (stat_strands),
`endif
    .m_last  (m_last)
  );

  function automatic logic [7:0] pk(input int d3, d2, d1, d0);
    return {d3[1:0], d2[1:0], d1[1:0], d0[1:0]};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got %0h expected none", m_data);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        check("m_data", int'(m_data), int'(e[7:0]));
        check("m_last", int'(m_last), int'(e[8]));
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] d, input logic f, input logic l,
                      input logic md, input logic [7:0] ed);
    bit ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_first = f;
    s_last  = l;
    s_mode  = md;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 expected 1");
    end else begin
      expq.push_back({l, ed});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_first = 1'b0;
    s_last  = 1'b0;
    s_mode  = 1'b0;
    m_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_data", int'(m_data), 0);
    check("rst_m_last", int'(m_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Encode strand spanning two beats, then an implicit new strand
    send(pk(1,3,0,2), 1, 0, 0, pk(1,2,1,2));
    send(pk(2,2,3,1), 0, 1, 0, pk(0,0,1,2));
    send(pk(3,0,0,0), 0, 0, 0, pk(3,1,0,0));

    // Decode round-trip
    send(pk(1,2,1,2), 1, 0, 1, pk(1,3,0,2));
    send(pk(0,0,1,2), 0, 1, 1, pk(2,2,3,1));

    // Single-beat strand, then a beat with no s_first after it
    send(pk(3,3,3,3), 1, 1, 1, pk(3,2,1,0));
    send(pk(1,1,1,1), 0, 1, 0, pk(1,0,0,0));

    // Backpressure: second beat waits while first is held
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = pk(1,3,0,2);
    s_first = 1'b1;
    s_last  = 1'b0;
    s_mode  = 1'b0;
    @(negedge clk);
    check("bp_ready_a", int'(s_ready), 1);
    expq.push_back({1'b0, pk(1,2,1,2)});
    @(posedge clk);
    #1;
    s_data  = pk(2,2,3,1);
    s_first = 1'b0;
    s_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_s_ready", int'(s_ready), 0);
      check("bp_m_valid", int'(m_valid), 1);
      check("bp_m_data", int'(m_data), int'(pk(1,2,1,2)));
      if (k < 2) @(posedge clk);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_b", int'(s_ready), 1);
    expq.push_back({1'b1, pk(0,0,1,2)});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-strand drops the held beat
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = pk(1,3,0,2);
    s_first = 1'b1;
    s_last  = 1'b0;
    s_mode  = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("held_valid", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(m_valid), 0);
    check("mid_rst_data", int'(m_data), 0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    send(pk(2,2,3,1), 0, 0, 0, pk(2,0,1,2));

    // Mode switch mid-strand uses the raw carried digit
    send(pk(1,3,0,2), 1, 0, 0, pk(1,2,1,2));
    send(pk(0,0,1,2), 0, 1, 1, pk(2,2,3,1));

    for (int k = 0; k < 20 && expq.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain_left", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
